// File: rtl/lru_update_sequencer.sv
`default_nettype none
// ============================================================================
// lru_update_sequencer : drives hit/fill updates into LRU_buffer and runs the
// refill handshake on a miss. Optional counters: LRU_SEQ_STATS_EN.
// Revision: 1.0
// ============================================================================
module lru_update_sequencer #(
  parameter int WAYS  = 8,
  parameter int IDX_W = 7
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_req_valid,
  output logic             o_req_ready,
  input  logic             i_req_hit,
  input  logic [WAYS-1:0]  i_req_hit_way_8,
  input  logic [IDX_W-1:0] i_req_addr_7,
  output logic             o_lru_write_enable,
  output logic             o_hit_sig,
  output logic [WAYS-1:0]  o_hit_way_8,
  output logic [IDX_W-1:0] o_addr_7,
  input  logic [WAYS-1:0]  i_lru_flag,
  output logic             o_refill_valid,
  output logic [WAYS-1:0]  o_refill_way_8,
  output logic [IDX_W-1:0] o_refill_addr_7,
  input  logic             i_refill_done,
`ifdef LRU_SEQ_STATS_EN
  output logic [15:0]      o_hit_cnt,
  output logic [15:0]      o_miss_cnt,
`endif
  output logic             o_err
);

  localparam logic [WAYS-1:0] WAY0 = WAYS'(1);

  typedef enum logic [2:0] {
    IDLE        = 3'd0,
    HIT_UPD     = 3'd1,
    VICTIM_RD   = 3'd2,
    REFILL_WAIT = 3'd3,
    MISS_UPD    = 3'd4
  } state_t;

  state_t            state, state_nx;
  logic [IDX_W-1:0]  set_q, set_nx;
  logic [WAYS-1:0]   victim_q, victim_nx;
  logic              ready_nx, we_nx, hit_sig_nx, refill_valid_nx, err_nx;
  logic [WAYS-1:0]   hit_way_nx, refill_way_nx;
  logic [IDX_W-1:0]  addr_nx, refill_addr_nx;
  logic [WAYS-1:0]   way_low, flag_low;
  logic              way_multi, flag_multi, hit_ok;

  // x & -x isolates the lowest set bit; x & (x-1) is nonzero when more than one bit is set
  assign way_low    = i_req_hit_way_8 & (~i_req_hit_way_8 + WAY0);
  assign way_multi  = |(i_req_hit_way_8 & (i_req_hit_way_8 - WAY0));
  assign flag_low   = i_lru_flag & (~i_lru_flag + WAY0);
  assign flag_multi = |(i_lru_flag & (i_lru_flag - WAY0));
  assign hit_ok     = i_req_hit && (|i_req_hit_way_8);

  always_comb begin
    state_nx        = state;
    set_nx          = set_q;
    victim_nx       = victim_q;
    ready_nx        = 1'b0;
    we_nx           = 1'b0;
    hit_sig_nx      = 1'b0;
    hit_way_nx      = '0;
    addr_nx         = set_q;
    refill_valid_nx = 1'b0;
    refill_way_nx   = '0;
    refill_addr_nx  = '0;
    err_nx          = o_err;
    case (state)
      IDLE: begin
        ready_nx = 1'b1;
        addr_nx  = '0;
        if (i_req_valid) begin
          set_nx   = i_req_addr_7;
          addr_nx  = i_req_addr_7;
          ready_nx = 1'b0;
          if (i_req_hit && way_multi) err_nx = 1'b1;
          if (hit_ok) begin
            state_nx   = HIT_UPD;
            we_nx      = 1'b1;
            hit_sig_nx = 1'b1;
            hit_way_nx = way_low;
          end else begin
            // a hit with no way bit set is treated as a miss
            if (i_req_hit) err_nx = 1'b1;
            state_nx = VICTIM_RD;
          end
        end
      end
      VICTIM_RD: begin
        victim_nx = (i_lru_flag == '0) ? WAY0 : flag_low;
        if ((i_lru_flag == '0) || flag_multi) err_nx = 1'b1;
        state_nx        = REFILL_WAIT;
        refill_valid_nx = 1'b1;
        refill_way_nx   = victim_nx;
        refill_addr_nx  = set_q;
      end
      REFILL_WAIT: begin
        if (i_refill_done) begin
          state_nx   = MISS_UPD;
          we_nx      = 1'b1;
          hit_way_nx = victim_q;
        end else begin
          refill_valid_nx = 1'b1;
          refill_way_nx   = victim_q;
          refill_addr_nx  = set_q;
        end
      end
      default: begin
        state_nx = IDLE;
        ready_nx = 1'b1;
        addr_nx  = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state              <= IDLE;
      set_q              <= '0;
      victim_q           <= '0;
      o_req_ready        <= 1'b1;
      o_lru_write_enable <= 1'b0;
      o_hit_sig          <= 1'b0;
      o_hit_way_8        <= '0;
      o_addr_7           <= '0;
      o_refill_valid     <= 1'b0;
      o_refill_way_8     <= '0;
      o_refill_addr_7    <= '0;
      o_err              <= 1'b0;
    end else begin
      state              <= state_nx;
      set_q              <= set_nx;
      victim_q           <= victim_nx;
      o_req_ready        <= ready_nx;
      o_lru_write_enable <= we_nx;
      o_hit_sig          <= hit_sig_nx;
      o_hit_way_8        <= hit_way_nx;
      o_addr_7           <= addr_nx;
      o_refill_valid     <= refill_valid_nx;
      o_refill_way_8     <= refill_way_nx;
      o_refill_addr_7    <= refill_addr_nx;
      o_err              <= err_nx;
    end
  end

`ifdef LRU_SEQ_STATS_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      o_hit_cnt  <= '0;
      o_miss_cnt <= '0;
    end else if (state == IDLE && i_req_valid) begin
      if (hit_ok) begin
        if (o_hit_cnt != 16'hFFFF) o_hit_cnt <= o_hit_cnt + 16'd1;
      end else begin
        if (o_miss_cnt != 16'hFFFF) o_miss_cnt <= o_miss_cnt + 16'd1;
      end
    end
  end
`endif

endmodule
`default_nettype wire

// File: tb/tb_lru_update_sequencer.sv
`default_nettype none
// ============================================================================
// tb_lru_update_sequencer : directed bench with a per-cycle phase model.
// Revision: 1.0
// ============================================================================
module tb_lru_update_sequencer;
  localparam int P_RST = 0, P_IDLE = 1, P_UPD = 2, P_VIC = 3, P_WAIT = 4;

  logic       clk = 1'b0;
  logic       rst;
  logic       req_valid, req_ready, req_hit;
  logic [7:0] req_way;
  logic [6:0] req_addr;
  logic       we, hit_sig;
  logic [7:0] hit_way;
  logic [6:0] addr;
  logic [7:0] lru_flag;
  logic       refill_valid;
  logic [7:0] refill_way;
  logic [6:0] refill_addr;
  logic       refill_done, err;
`ifdef LRU_SEQ_STATS_EN
  logic [15:0] hit_cnt, miss_cnt;
`endif

  always #5 clk = ~clk;

  lru_update_sequencer #(.WAYS(8), .IDX_W(7)) dut (
    .clk(clk), .rst(rst),
    .i_req_valid(req_valid), .o_req_ready(req_ready), .i_req_hit(req_hit),
    .i_req_hit_way_8(req_way), .i_req_addr_7(req_addr),
    .o_lru_write_enable(we), .o_hit_sig(hit_sig), .o_hit_way_8(hit_way), .o_addr_7(addr),
    .i_lru_flag(lru_flag),
    .o_refill_valid(refill_valid), .o_refill_way_8(refill_way), .o_refill_addr_7(refill_addr),
    .i_refill_done(refill_done),
`ifdef LRU_SEQ_STATS_EN
    .o_hit_cnt(hit_cnt), .o_miss_cnt(miss_cnt),
`endif
    .o_err(err)
  );

  // model state: which phase the current cycle must show, plus its payload
  int         ph;
  logic [7:0] e_way;
  logic [6:0] e_addr;
  logic       e_hs;
  logic       err_m;
  logic [15:0] hit_m, miss_m;
  bit         chk_en = 1'b0;
  int         n_cmp = 0, n_bad = 0, we_cnt = 0, cyc = 0;
  logic [7:0] cap_way, cap_rway;
  logic [6:0] cap_addr, cap_raddr;
  logic       cap_hs;

  task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  function automatic logic [7:0] lowest(input logic [7:0] v);
    for (int i = 0; i < 8; i++) if (v[i]) return 8'(1 << i);
    return 8'h01;
  endfunction

  always @(posedge clk) cyc++;
  always @(negedge clk) if (we === 1'b1) we_cnt++;

  always @(negedge clk) if (chk_en) begin
    chk("req_ready",    16'(req_ready),    16'(ph == P_IDLE || ph == P_RST));
    chk("write_enable", 16'(we),           16'(ph == P_UPD));
    chk("refill_valid", 16'(refill_valid), 16'(ph == P_WAIT));
    chk("err",          16'(err),          16'(err_m));
`ifdef LRU_SEQ_STATS_EN
    chk("hit_cnt",  hit_cnt,  hit_m);
    chk("miss_cnt", miss_cnt, miss_m);
`endif
    case (ph)
      P_UPD: begin
        chk("hit_sig", 16'(hit_sig), 16'(e_hs));
        chk("hit_way", 16'(hit_way), 16'(e_way));
        chk("addr",    16'(addr),    16'(e_addr));
      end
      P_VIC:  chk("victim_addr", 16'(addr), 16'(e_addr));
      P_WAIT: begin
        chk("refill_way",  16'(refill_way),  16'(e_way));
        chk("refill_addr", 16'(refill_addr), 16'(e_addr));
      end
      P_RST: begin
        chk("rst_hit_sig",     16'(hit_sig),     16'h0);
        chk("rst_hit_way",     16'(hit_way),     16'h0);
        chk("rst_addr",        16'(addr),        16'h0);
        chk("rst_refill_way",  16'(refill_way),  16'h0);
        chk("rst_refill_addr", 16'(refill_addr), 16'h0);
      end
      default: ;
    endcase
  end

  task automatic next();
    @(posedge clk);
    #1;
  endtask

  task automatic bump(input bit is_hit);
    if (is_hit) begin
      if (hit_m != 16'hFFFF) hit_m++;
    end else begin
      if (miss_m != 16'hFFFF) miss_m++;
    end
  endtask

  task automatic capture_upd();
    @(negedge clk);
    cap_way  = hit_way;
    cap_addr = addr;
    cap_hs   = hit_sig;
  endtask

  // called in an idle cycle; leaves the bench in the following idle cycle
  task automatic do_hit(input logic [6:0] a, input logic [7:0] w, input bit hold);
    req_valid = 1'b1; req_hit = 1'b1; req_way = w; req_addr = a;
    next();
    if (!hold) req_valid = 1'b0;
    ph = P_UPD; e_hs = 1'b1; e_way = lowest(w); e_addr = a;
    if ($countones(w) != 1) err_m = 1'b1;
    bump(1'b1);
    capture_upd();
    next();
    ph = P_IDLE;
  endtask

  task automatic do_miss(input logic [6:0] a, input bit hb, input logic [7:0] w,
                         input logic [7:0] flag, input int nwait, input bit early);
    req_valid = 1'b1; req_hit = hb; req_way = w; req_addr = a;
    next();
    req_valid = 1'b0; lru_flag = flag; refill_done = early;
    ph = P_VIC; e_addr = a;
    if (hb) err_m = 1'b1;
    bump(1'b0);
    next();
    lru_flag = 8'hA5; refill_done = 1'b0;
    ph = P_WAIT; e_way = (flag == 8'h00) ? 8'h01 : lowest(flag);
    if ($countones(flag) != 1) err_m = 1'b1;
    @(negedge clk);
    cap_rway = refill_way; cap_raddr = refill_addr;
    for (int i = 0; i < nwait; i++) next();
    refill_done = 1'b1;
    next();
    refill_done = 1'b0;
    ph = P_UPD; e_hs = 1'b0;
    capture_upd();
    next();
    ph = P_IDLE;
  endtask

  initial begin
    #100000;
    $display("FAIL timeout: got no finish, expected finish before 100us");
    $fatal(1);
  end

  initial begin
    int w0;
    rst = 1'b0; req_valid = 1'b0; req_hit = 1'b0; req_way = '0; req_addr = '0;
    lru_flag = 8'hA5; refill_done = 1'b0;
    ph = P_RST; err_m = 1'b0; hit_m = '0; miss_m = '0;
    e_way = '0; e_addr = '0; e_hs = 1'b0;
    chk_en = 1'b1;
    next(); next();
    rst = 1'b1;
    next(); ph = P_IDLE;
    next();

    // hit, set 5, way 8'h08
    do_hit(7'd5, 8'h08, 1'b0);
    chk("pin_hit_way",  16'(cap_way),  16'h08);
    chk("pin_hit_addr", 16'(cap_addr), 16'd5);
    chk("pin_hit_sig",  16'(cap_hs),   16'h1);
    next();

    // miss, set 127, victim 8'h40, done three cycles into the wait; early done ignored
    do_miss(7'd127, 1'b0, 8'hFF, 8'h40, 2, 1'b1);
    chk("pin_refill_way",  16'(cap_rway),  16'h40);
    chk("pin_refill_addr", 16'(cap_raddr), 16'd127);
    chk("pin_fill_way",    16'(cap_way),   16'h40);
    chk("pin_fill_sig",    16'(cap_hs),    16'h0);

    // back-to-back hits with valid held high
    w0 = we_cnt;
    do_hit(7'd10, 8'h01, 1'b1);
    do_hit(7'd11, 8'h02, 1'b1);
    do_hit(7'd12, 8'h80, 1'b0);
    next();
    chk("pin_b2b_we_pulses", 16'(we_cnt - w0), 16'd3);

    // empty victim flag falls back to way 0
    do_miss(7'd3, 1'b0, 8'h00, 8'h00, 0, 1'b0);
    chk("pin_zero_flag_way", 16'(cap_way), 16'h01);
    chk("pin_zero_flag_err", 16'(err),     16'h1);

    // reset during REFILL_WAIT
    w0 = we_cnt;
    req_valid = 1'b1; req_hit = 1'b0; req_addr = 7'd33;
    next();
    req_valid = 1'b0; lru_flag = 8'h10; ph = P_VIC; e_addr = 7'd33; bump(1'b0);
    next();
    lru_flag = 8'hA5; ph = P_WAIT; e_way = 8'h10;
    next();
    rst = 1'b0; err_m = 1'b0; hit_m = '0; miss_m = '0; ph = P_RST;
    next();
    rst = 1'b1;
    next();
    ph = P_IDLE; refill_done = 1'b1;
    next();
    refill_done = 1'b0;
    repeat (3) next();
    chk("pin_rst_no_we", 16'(we_cnt - w0), 16'd0);
    chk("pin_rst_err",   16'(err),         16'h0);

    // multi-bit hit way uses the lowest bit
    do_hit(7'd9, 8'h0C, 1'b0);
    chk("pin_multi_hit_way", 16'(cap_way), 16'h04);
    chk("pin_multi_hit_err", 16'(err),     16'h1);
    next();

    // zero-way hit becomes a miss; multi-bit victim flag uses lowest bit
    do_miss(7'd20, 1'b1, 8'h00, 8'h30, 1, 1'b0);
    chk("pin_multi_flag_way", 16'(cap_way), 16'h10);
    do_hit(7'd64, 8'h20, 1'b0);
    repeat (2) next();

    chk_en = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
`default_nettype wire
